button_pulse_gen: RTL and testbench

Upstream conditioning stage for the 4-bit counter. It synchronises a raw push-button, debounces it and emits a one-clock enable pulse per press. That pulse drives the counter's `en` input directly, so one physical press produces exactly one count. It sits between the board button pin and the counter, sharing the counter's clock and reset.

---
 rtl/button_pulse_gen_if.sv | 22 ++
 rtl/button_pulse_gen.sv | 170 +++++++++++++++++
 tb/tb_button_pulse_gen.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/button_pulse_gen_if.sv
// Button conditioning bus: the raw pin going in, the debounced pulses and level coming out.
// The master side drives the raw pin and consumes the outputs; the slave is the conditioner.
interface button_pulse_gen_if;
    logic btn_in;
    logic btn_pulse;
    logic btn_rel_pulse;
    logic btn_level;

    modport master (
        output btn_in,
        input  btn_pulse,
        input  btn_rel_pulse,
        input  btn_level
    );

    modport slave (
        input  btn_in,
        output btn_pulse,
        output btn_rel_pulse,
        output btn_level
    );
endinterface

// File: rtl/button_pulse_gen.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, one-cycle press and
// release pulses, and a debounced level. The press pulse feeds the counter's enable.
// Optional auto-repeat of the press pulse while the button stays held is built when the
// macro BUTTON_PULSE_GEN_AUTO_REPEAT_EN is defined. Otherwise each press gives exactly one pulse.
module button_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter bit ACTIVE_LOW      = 1'b0
`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
`endif
) (
    input  logic              clk,
    input  logic              rst,
    button_pulse_gen_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    // Raw pin value while the button is not pressed.
    localparam logic             RELEASED_RAW = ACTIVE_LOW;
    // Final count of a debounce window. The window also includes the sample that opened it.
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             sync;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             pulse_q;
    logic             pulse_n;
    logic             rel_q;
    logic             rel_n;
    logic             level_q;
    logic             level_n;

`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
    localparam logic [31:0] RPT_FIRST = 32'(REPEAT_DELAY);
    localparam logic [31:0] RPT_WRAP  = 32'(REPEAT_DELAY + REPEAT_PERIOD);

    logic [31:0] rcnt;
    logic [31:0] rcnt_n;
    logic [31:0] rcnt_inc;
`endif

    // Bring the asynchronous pin into the clock domain; reset parks it at "released".
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so s2 takes the old s1, giving two real flop stages.
        if (rst) begin
            s1 <= RELEASED_RAW;
            s2 <= RELEASED_RAW;
        end else begin
            s1 <= bus.btn_in;
            s2 <= s1;
        end
    end

    // Pressed = 1 regardless of pin polarity.
    assign sync = ACTIVE_LOW ? ~s2 : s2;

    // State, debounce counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pulse_q <= 1'b0;
            rel_q   <= 1'b0;
            level_q <= 1'b0;
`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
            rcnt    <= '0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pulse_q <= pulse_n;
            rel_q   <= rel_n;
            level_q <= level_n;
`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
            rcnt    <= rcnt_n;
`endif
        end
    end

    // Debounce decisions. A level change is accepted once DEBOUNCE_CYCLES further samples agree.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_n = state;
        cnt_n   = cnt;
        pulse_n = 1'b0;
        rel_n   = 1'b0;
        level_n = level_q;

        case (state)
            IDLE: begin
                if (sync) begin
                    state_n = PRESS_WAIT;
                    cnt_n   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = HELD;
                    pulse_n = 1'b1;
                    level_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!sync) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    // A bounce on release. Stay pressed and do not issue a new pulse.
                    state_n = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                    rel_n   = 1'b1;
                    level_n = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
        // rcnt measures time spent held. After the first repeat it folds back to RPT_FIRST
        // each period, so it never has to wrap.
        rcnt_n   = rcnt;
        rcnt_inc = rcnt + 32'd1;
        case (state)
            IDLE, PRESS_WAIT: rcnt_n = '0;
            HELD: begin
                rcnt_n = rcnt_inc;
                if (rcnt_inc == RPT_WRAP) begin
                    rcnt_n = RPT_FIRST;
                end
                if (sync && (rcnt_inc == RPT_FIRST || rcnt_inc == RPT_WRAP)) begin
                    pulse_n = 1'b1;
                end
            end
            default: rcnt_n = rcnt;
        endcase
`endif
    end

    assign bus.btn_pulse     = pulse_q;
    assign bus.btn_rel_pulse = rel_q;
    assign bus.btn_level     = level_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Self-checking bench for button_pulse_gen with DEBOUNCE_CYCLES=4.
// The reference model treats the debouncer as a run-length rule: a sample two edges old
// that differs from the accepted level extends a run, and a run of DEBOUNCE_CYCLES+1
// flips the level. Directed scenarios pin exact pulse edges, then random runs follow.
// The auto-repeat checks are included when BUTTON_PULSE_GEN_AUTO_REPEAT_EN is defined.
module tb_button_pulse_gen;

    localparam int DB = 4;
`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
    localparam int RD = 10;
    localparam int RP = 5;
`endif

    logic clk;
    logic rst;
    button_pulse_gen_if bus ();

    button_pulse_gen #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(4),
        .ACTIVE_LOW(1'b0)
`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int edge_n     = 0;
    bit check_en   = 1'b0;
    int pulse_q[$];
    int rel_q[$];

    // Reference model state
    bit pipe[$];
    int run;
    bit m_level;
    bit m_pulse;
    bit m_rel;
    bit m_sync;
    bit m_held;
`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
    int hc;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Model: advances once per clock edge from the inputs sampled at that edge.
    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            pipe     = '{1'b0, 1'b0};
            run      = 0;
            m_level  = 1'b0;
            m_pulse  = 1'b0;
            m_rel    = 1'b0;
            check_en = 1'b1;
`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
            hc       = 0;
`endif
        end else begin
            m_sync = pipe.pop_front();
            pipe.push_back(bus.btn_in);
            m_held  = m_level && (run == 0);
            m_pulse = 1'b0;
            m_rel   = 1'b0;
            if (m_sync != m_level) run++;
            else                   run = 0;
            if (run == DB + 1) begin
                m_level = m_sync;
                run     = 0;
                if (m_sync) m_pulse = 1'b1;
                else        m_rel   = 1'b1;
`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
                hc = 0;
            end else if (m_held) begin
                hc++;
                if (m_sync && hc >= RD && ((hc - RD) % RP) == 0) m_pulse = 1'b1;
`endif
            end
        end
    end

    // Compare DUT outputs with the model on every falling edge, and log pulse edges.
    always @(negedge clk) begin
        if (check_en) begin
            check("btn_pulse", bus.btn_pulse, m_pulse);
            check("btn_rel_pulse", bus.btn_rel_pulse, m_rel);
            check("btn_level", bus.btn_level, m_level);
            if (bus.btn_pulse === 1'b1)     pulse_q.push_back(edge_n);
            if (bus.btn_rel_pulse === 1'b1) rel_q.push_back(edge_n);
        end
    end

    // The value is captured on the next rising edge.
    task automatic drive(input logic b);
        @(negedge clk);
        bus.btn_in = b;
    endtask

    function automatic int first_of(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    int cap;
    int lvl;
    int len;

    initial begin
        bus.btn_in = 1'b0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: nothing moves.
        repeat (20) drive(1'b0);
        check("t1_pulse_count", pulse_q.size(), 0);
        check("t1_rel_count", rel_q.size(), 0);
        check("t1_level", bus.btn_level, 0);

        // Clean press: the pulse appears 2 + DB edges after capture.
        pulse_q.delete();
        drive(1'b1);
        cap = edge_n + 1;
        repeat (29) drive(1'b1);
        check("t2_pulse_edge", first_of(pulse_q), cap + 6);
`ifndef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
        check("t2_pulse_count", pulse_q.size(), 1);
`endif
        check("t2_level", bus.btn_level, 1);

        // Release with a one-cycle glitch: the release is timed from the last 1->0 capture.
        pulse_q.delete();
        rel_q.delete();
        drive(1'b0);
        cap = edge_n + 1;
        drive(1'b0);
        drive(1'b1);
        repeat (20) drive(1'b0);
        check("t4_rel_edge", first_of(rel_q), cap + 3 + 6);
        check("t4_rel_count", rel_q.size(), 1);
`ifndef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
        check("t4_pulse_count", pulse_q.size(), 0);
`endif
        check("t4_level", bus.btn_level, 0);

        // Bouncy press 1,0,1,0 then steady 1: one pulse, timed from the last capture.
        pulse_q.delete();
        drive(1'b1);
        cap = edge_n + 1;
        drive(1'b0);
        drive(1'b1);
        drive(1'b0);
        repeat (20) drive(1'b1);
        check("t3_pulse_edge", first_of(pulse_q), cap + 4 + 6);
`ifndef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
        check("t3_pulse_count", pulse_q.size(), 1);
`endif
        repeat (20) drive(1'b0);

        // Reset in the middle of a press debounce, with the button still held.
        pulse_q.delete();
        drive(1'b1);
        cap = edge_n + 1;
        repeat (3) drive(1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_level_after_rst", bus.btn_level, 0);
        check("t5_pulse_after_rst", bus.btn_pulse, 0);
        repeat (15) drive(1'b1);
        check("t5_pulse_edge", first_of(pulse_q), cap + 5 + 6);
        check("t5_pulse_count", pulse_q.size(), 1);
        repeat (20) drive(1'b0);

`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
        // Auto-repeat: pulses at A, A+10, A+15, A+20, ...
        pulse_q.delete();
        drive(1'b1);
        cap = edge_n + 1;
        repeat (39) drive(1'b1);
        check("t6_count_min", (pulse_q.size() >= 4) ? 1 : 0, 1);
        if (pulse_q.size() >= 4) begin
            check("t6_first", pulse_q[0], cap + 6);
            check("t6_second", pulse_q[1], cap + 6 + 10);
            check("t6_third", pulse_q[2], cap + 6 + 15);
            check("t6_fourth", pulse_q[3], cap + 6 + 20);
        end
        repeat (20) drive(1'b0);
`endif

        // Random runs of random length, with occasional resets.
        for (int i = 0; i < 300; i++) begin
            lvl = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            repeat (len) drive(lvl[0]);
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clk);
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst = 1'b0;
            end
        end

        repeat (10) drive(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
